// File: rtl/ps2_pkg.sv
// Shared constants, event layout and receive FSM encoding for the PS/2 key decoder.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam int         PS2_EVT_W = 10;

    localparam int EV_CODE_LSB = 0;
    localparam int EV_CODE_MSB = 7;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, PS2CLK glitch filter, 11-bit frame FSM with timeout.
// byte_valid/byte_err pulse in the CHECK cycle, one cycle after the stop-bit strobe.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           clk_filt, strobe;
    logic [FCW-1:0] filt_cnt;
    rx_state_t      state, state_nxt;
    logic [3:0]     bit_cnt;
    logic [9:0]     shreg;
    logic [TCW-1:0] to_cnt;
    logic           timeout, frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {clk_s2, clk_s1}   <= 2'b11;
            {data_s2, data_s1} <= 2'b11;
        end else begin
            {clk_s2, clk_s1}   <= {clk_s1, ps2_clk};
            {data_s2, data_s1} <= {data_s1, ps2_data};
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive opposite sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                    strobe   <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign timeout = (state == SHIFT) && (to_cnt == TCW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strobe && !data_s2) state_nxt = SHIFT;
            SHIFT:   if (timeout) state_nxt = IDLE;
                     else if (strobe && bit_cnt == 4'd9) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // shreg collects d0..d7, parity, stop; the start bit is consumed by the IDLE exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (state == SHIFT) begin
            if (strobe) begin
                shreg   <= {data_s2, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
                to_cnt  <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign frame_good = (^shreg[8:0]) && shreg[9];

    always_comb begin
        byte_valid = (state == CHECK) && frame_good;
        byte_err   = ((state == CHECK) && !frame_good) || timeout;
        byte_data  = shreg[7:0];
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix decode, last-release register and event FIFO.
// Event visible 2 cycles after the stop-bit strobe; ev_ready=0 holds the head, full FIFO drops new events.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEPTH          = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2CLK,
    input  logic       PS2Data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic [7:0] last_release,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic                 byte_valid, byte_err;
    logic [7:0]           byte_data;
    logic                 ext_f, brk_f;
    logic                 is_prefix, push_req, do_push, pop, empty, full;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [PS2_EVT_W-1:0] mem [DEPTH];
    logic [PS2_EVT_W-1:0] head, hold_q, out_evt, new_evt;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (CLK),
        .rst_n     (RST_N),
        .ps2_clk   (PS2CLK),
        .ps2_data  (PS2Data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_err  (byte_err)
    );

    assign frame_err = byte_err;
    assign is_prefix = (byte_data == PS2_EXT) || (byte_data == PS2_BRK);
    assign push_req  = byte_valid && !is_prefix;
    assign new_evt   = {ext_f, brk_f, byte_data};

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign do_push  = push_req && (!full || pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
            last_release <= PS2_BRK;
        end else if (byte_err) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == PS2_EXT) begin
                ext_f <= 1'b1;
            end else if (byte_data == PS2_BRK) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
                if (brk_f) last_release <= byte_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= new_evt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            overflow <= push_req && full && !pop;
            if (!empty)  hold_q <= head;
        end
    end

    // When empty the outputs keep showing the last head rather than a stale slot.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign out_evt = empty ? hold_q : head;
    assign ev_code = out_evt[EV_CODE_MSB:EV_CODE_LSB];
    assign ev_brk  = out_evt[EV_BRK_BIT];
    assign ev_ext  = out_evt[EV_EXT_BIT];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, event/err/overflow monitor, per-scenario checks.
module tb_ps2_key_decoder;
    localparam int FL    = 4;
    localparam int TMO   = 300;
    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PS2CLK = 1'b1;
    logic       PS2Data = 1'b1;
    logic       ev_ready = 1'b1;
    logic       ev_valid, ev_ext, ev_brk, frame_err, overflow;
    logic [7:0] ev_code, last_release;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int err_cnt = 0, err_cyc = 0, ovf_cnt = 0, vld_cyc = 0, lr_cyc = 0;
    int first_pop = 0, last_pop = 0;
    logic prev_v = 1'b0;
    logic [7:0] prev_lr = 8'hF0;
    logic [9:0] evq [$];

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .PS2CLK(PS2CLK), .PS2Data(PS2Data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_brk(ev_brk), .last_release(last_release),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ev_valid && ev_ready) begin
            if (evq.size() == 0) first_pop = cyc;
            last_pop = cyc;
            evq.push_back({ev_ext, ev_brk, ev_code});
        end
        if (frame_err) begin err_cnt++; err_cyc = cyc; end
        if (overflow) ovf_cnt++;
        if (ev_valid && !prev_v) vld_cyc = cyc;
        prev_v = ev_valid;
        if (last_release != prev_lr) lr_cyc = cyc;
        prev_lr = last_release;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2Data = b;
        clk_wait(8);
        PS2CLK = 1'b0;
        fall_cyc = cyc;
        clk_wait(8);
        PS2CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
        clk_wait(20);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        clk_wait(3);
        checks++;
        if ({ev_valid, ev_ext, ev_brk, frame_err, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {ev_valid, ev_ext, ev_brk, frame_err, overflow});
        end
        checks++;
        if (ev_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h want=00", ev_code); end
        checks++;
        if (last_release !== 8'hF0) begin failures++; $display("FAIL reset_last_release got=%h want=f0", last_release); end
        RST_N = 1'b1;
        clk_wait(5);
    endtask

    task automatic test_single();
        int e0;
        e0 = err_cnt;
        evq.delete();
        send_frame(8'h1C, 1'b0);
        checks++;
        if (evq.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", evq.size()); end
        else begin
            checks++;
            if (evq[0] !== 10'h01C) begin failures++; $display("FAIL single_event got=%h want=01c", evq[0]); end
        end
        checks++;
        if (err_cnt != e0) begin failures++; $display("FAIL single_no_err got=%0d want=%0d", err_cnt, e0); end
        checks++;
        if (vld_cyc - fall_cyc != 8) begin failures++; $display("FAIL single_latency got=%0d want=8", vld_cyc - fall_cyc); end
    endtask

    task automatic test_break();
        evq.delete();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        checks++;
        if (evq.size() != 1) begin failures++; $display("FAIL break_count got=%0d want=1", evq.size()); end
        else begin
            checks++;
            if (evq[0] !== 10'h11C) begin failures++; $display("FAIL break_event got=%h want=11c", evq[0]); end
        end
        checks++;
        if (last_release !== 8'h1C) begin failures++; $display("FAIL break_last_release got=%h want=1c", last_release); end
        checks++;
        if (lr_cyc != vld_cyc) begin failures++; $display("FAIL break_lr_timing got=%0d want=%0d", lr_cyc, vld_cyc); end
    endtask

    task automatic test_ext_break();
        evq.delete();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h1D, 1'b0);
        checks++;
        if (evq.size() != 2) begin failures++; $display("FAIL extbrk_count got=%0d want=2", evq.size()); end
        else begin
            checks++;
            if (evq[0] !== 10'h375) begin failures++; $display("FAIL extbrk_event got=%h want=375", evq[0]); end
            checks++;
            if (evq[1] !== 10'h01D) begin failures++; $display("FAIL extbrk_flags_cleared got=%h want=01d", evq[1]); end
        end
        checks++;
        if (last_release !== 8'h75) begin failures++; $display("FAIL extbrk_last_release got=%h want=75", last_release); end
    endtask

    task automatic test_parity();
        int e0;
        evq.delete();
        send_frame(8'hF0, 1'b0);
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        checks++;
        if (err_cnt != e0 + 1) begin failures++; $display("FAIL parity_err_count got=%0d want=%0d", err_cnt, e0 + 1); end
        checks++;
        if (err_cyc - fall_cyc != 7) begin failures++; $display("FAIL parity_err_timing got=%0d want=7", err_cyc - fall_cyc); end
        checks++;
        if (evq.size() != 0) begin failures++; $display("FAIL parity_no_event got=%0d want=0", evq.size()); end
        send_frame(8'h1C, 1'b0);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h01C) begin
            failures++;
            $display("FAIL parity_recover got_n=%0d got=%h want=01c", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF);
        end
    endtask

    task automatic test_timeout();
        int e0;
        evq.delete();
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        clk_wait(TMO + 50);
        checks++;
        if (err_cnt != e0 + 1) begin failures++; $display("FAIL timeout_err_count got=%0d want=%0d", err_cnt, e0 + 1); end
        checks++;
        if (err_cyc - fall_cyc < TMO || err_cyc - fall_cyc > TMO + 10) begin
            failures++;
            $display("FAIL timeout_delay got=%0d want=%0d..%0d", err_cyc - fall_cyc, TMO, TMO + 10);
        end
        send_frame(8'h29, 1'b0);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h029) begin
            failures++;
            $display("FAIL timeout_recover got_n=%0d got=%h want=029", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF);
        end
    endtask

    task automatic test_midframe_reset();
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        RST_N = 1'b0;
        clk_wait(2);
        RST_N = 1'b1;
        clk_wait(TMO + 20);
        checks++;
        if (err_cnt != e0) begin failures++; $display("FAIL midreset_no_err got=%0d want=%0d", err_cnt, e0); end
        checks++;
        if (last_release !== 8'hF0) begin failures++; $display("FAIL midreset_last_release got=%h want=f0", last_release); end
        evq.delete();
        send_frame(8'h1C, 1'b0);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h01C) begin
            failures++;
            $display("FAIL midreset_recover got_n=%0d got=%h want=01c", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        logic [7:0] code;
        ev_ready = 1'b0;
        o0 = ovf_cnt;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            code = 8'(i);
            send_frame(code, 1'b0);
        end
        checks++;
        if (ovf_cnt != o0 + 1) begin failures++; $display("FAIL ovf_count got=%0d want=%0d", ovf_cnt, o0 + 1); end
        checks++;
        if (ev_valid !== 1'b1 || {ev_ext, ev_brk, ev_code} !== 10'h001) begin
            failures++;
            $display("FAIL ovf_head_hold got_v=%b got=%h want_v=1 want=001", ev_valid, {ev_ext, ev_brk, ev_code});
        end
        evq.delete();
        ev_ready = 1'b1;
        clk_wait(DEPTH + 6);
        checks++;
        if (evq.size() != DEPTH) begin failures++; $display("FAIL drain_count got=%0d want=%0d", evq.size(), DEPTH); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (evq[i] !== 10'(i + 1)) begin
                    failures++;
                    $display("FAIL drain_order idx=%0d got=%h want=%h", i, evq[i], 10'(i + 1));
                end
            end
            checks++;
            if (last_pop - first_pop != DEPTH - 1) begin
                failures++;
                $display("FAIL drain_no_bubble got=%0d want=%0d", last_pop - first_pop, DEPTH - 1);
            end
        end
        checks++;
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b want=0", ev_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_break();
        test_ext_break();
        test_parity();
        test_timeout();
        test_midframe_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
